// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared state encoding and BCD constants for the sequential BCD-to-binary decoder.
package bcd_to_bin_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic digit_bad(input logic [3:0] d);
    return (d > BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq_digit_mac.sv
// One Horner step: acc_out = acc_in*10 + d, built from shifts (no multiplier).
// Purely combinational; out-of-range digits still accumulate modulo 2**BW and raise bad.
module bcd_digit_mac
  import bcd_to_bin_seq_pkg::*;
#(
  parameter int BW = 7
) (
  input  logic [BW-1:0] acc_in,
  input  logic [3:0]    d,
  output logic [BW-1:0] acc_out,
  output logic          bad
);

  always_comb begin
    acc_out = (acc_in << 3) + (acc_in << 1) + BW'(d);
    bad     = digit_bad(d);
  end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// NDIG-digit packed BCD to BW-bit binary, one digit per clock; done pulses NDIG+1 cycles after start.
// start is ignored while busy or done (no queuing); the operand is registered on the start edge.
module bcd_to_bin_seq
  import bcd_to_bin_seq_pkg::*;
#(
  parameter int NDIG = 2,
  parameter int BW   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd,
  output logic              busy,
  output logic              done,
  output logic [BW-1:0]     bin,
  output logic              err
);

  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t            state, state_n;
  logic [4*NDIG-1:0] sh;
  logic [BW-1:0]     acc;
  logic [BW-1:0]     acc_nxt;
  logic              err_s;
  logic              bad;
  logic [CW-1:0]     cnt;
  logic              err_nxt;

  bcd_digit_mac #(.BW(BW)) u_mac (
    .acc_in  (acc),
    .d       (sh[4*NDIG-1 -: 4]),
    .acc_out (acc_nxt),
    .bad     (bad)
  );

  assign err_nxt = err_s | bad;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_CONV;
      S_CONV:  if (cnt == '0) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      sh    <= '0;
      acc   <= '0;
      err_s <= 1'b0;
      cnt   <= '0;
      bin   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (start) begin
            sh    <= bcd;
            acc   <= '0;
            err_s <= 1'b0;
            cnt   <= CW'(NDIG - 1);
          end
        end
        S_CONV: begin
          acc   <= acc_nxt;
          err_s <= err_nxt;
          sh    <= sh << 4;
          cnt   <= cnt - 1'b1;
          // Final digit: publish the result together with the sticky error
          if (cnt == '0) begin
            bin <= err_nxt ? '0 : acc_nxt;
            err <= err_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == S_CONV);
  assign done = (state == S_DONE);

endmodule
